// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;

  localparam logic [7:0]  DEFAULT_PAT_C = 8'b0000_1101;
  localparam int unsigned DEFAULT_LEN_C = 4;

  // Lengths of 0 are meaningless, so they map to 1; oversize lengths saturate.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Control/data bundle between a bit-stream source and the sequence detector.
interface seq_det_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               in;
  logic               en;
  logic               mode_ovl;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat_in;
  logic [LEN_W-1:0]   len_in;
  logic               cnt_clr;
  logic               z;
  logic               armed;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output in, en, mode_ovl, pat_load, pat_in, len_in, cnt_clr,
    input  z, armed, match_cnt
  );

  modport slave (
    input  in, en, mode_ovl, pat_load, pat_in, len_in, cnt_clr,
    output z, armed, match_cnt
  );
endinterface

// File: rtl/seq_det_hist.sv
// History shift register with a saturating count of valid bits held.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               restart,
  input  logic               din,
  output logic [MAX_LEN-1:0] hist_n,
  output logic [LEN_W-1:0]   fill_n,
  output logic [LEN_W-1:0]   fill_d
);

  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  always_comb begin
    hist_n = MAX_LEN'({hist_q, din});
    fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    fill_d = fill_q;
    if (rst || clr) begin
      fill_d = '0;
    end else if (shift) begin
      // restart drops the matched bits so none are reused
      fill_d = restart ? '0 : fill_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_q <= '0;
    end else if (shift) begin
      hist_q <= hist_n;
    end
    fill_q <= fill_d;
  end

endmodule

// File: rtl/seq_det_param.sv
// Run-time programmable serial pattern detector with overlap control and match counter.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = 4,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(DEFAULT_PAT_C),
  parameter int unsigned        DEFAULT_LEN = DEFAULT_LEN_C
) (
  input logic     clk,
  input logic     rst,
  seq_det_if.slave bus
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               z_q;
  logic               armed_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               shift;
  logic               match;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [LEN_W-1:0]   fill_d;

  assign shift = bus.en && !bus.pat_load;

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.pat_load),
    .shift   (shift),
    .restart (match && (bus.mode_ovl == MODE_NOVL)),
    .din     (bus.in),
    .hist_n  (hist_n),
    .fill_n  (fill_n),
    .fill_d  (fill_d)
  );

  always_comb begin
    // len == MAX_LEN shifts the one out, leaving an all-ones mask after the decrement
    mask  = (MAX_LEN'(1) << len_q) - MAX_LEN'(1);
    match = shift && (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);

    pat_d = pat_q;
    len_d = len_q;
    if (bus.pat_load) begin
      pat_d = bus.pat_in;
      len_d = LEN_W'(clamp_len(32'(bus.len_in), MAX_LEN));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEFAULT_PAT;
      len_q   <= LEN_W'(DEFAULT_LEN);
      z_q     <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      z_q     <= match;
      armed_q <= (fill_d >= len_d);
      if (bus.cnt_clr) begin
        cnt_q <= '0;
      end else if (match && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.z         = z_q;
  assign bus.armed     = armed_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed and randomized checks of two detectors (8- and 4-bit counters) against a queue model.
module tb_seq_det_param;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_det_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus_a ();
  seq_det_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) bus_b ();

  seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int total  = 0;
  int passed = 0;

  // Reference model: the valid bits seen since the last clear, newest at the back.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_z;
  bit         m_armed;
  int         m_cnt_a;
  int         m_cnt_b;
  logic       ovl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model(input logic r, e, d, o, l, input logic [7:0] p, input logic [3:0] li,
                       input logic c);
    bit hit;
    int n;
    hit = 0;
    if (r) begin
      q.delete();
      m_pat = DEFAULT_PAT_C;
      m_len = DEFAULT_LEN_C;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else begin
      if (l) begin
        m_pat = p;
        m_len = (li == 0) ? 1 : (li > 8) ? 8 : int'(li);
        q.delete();
      end else if (e) begin
        q.push_back(d);
        if (q.size() > 8) void'(q.pop_front());
        n = q.size();
        if (n >= m_len) begin
          hit = 1;
          // oldest of the last m_len bits pairs with pat[m_len-1]
          for (int k = 0; k < m_len; k++)
            if (q[n - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
        end
        if (hit && !o) q.delete();
      end
      if (c) begin
        m_cnt_a = 0;
        m_cnt_b = 0;
      end else if (hit) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 15) m_cnt_b++;
      end
    end
    m_z = hit;
    m_armed = !r && (q.size() >= m_len);
  endtask

  task automatic step(input logic r, e, d, o, l, input logic [7:0] p, input logic [3:0] li,
                      input logic c);
    rst = r;
    bus_a.en = e; bus_a.in = d; bus_a.mode_ovl = o; bus_a.pat_load = l;
    bus_a.pat_in = p; bus_a.len_in = li; bus_a.cnt_clr = c;
    bus_b.en = e; bus_b.in = d; bus_b.mode_ovl = o; bus_b.pat_load = l;
    bus_b.pat_in = p; bus_b.len_in = li; bus_b.cnt_clr = c;
    @(posedge clk);
    model(r, e, d, o, l, p, li, c);
    #1;
    chk("z_a", 32'(bus_a.z), 32'(m_z));
    chk("armed_a", 32'(bus_a.armed), 32'(m_armed));
    chk("cnt_a", 32'(bus_a.match_cnt), 32'(m_cnt_a));
    chk("z_b", 32'(bus_b.z), 32'(m_z));
    chk("armed_b", 32'(bus_b.armed), 32'(m_armed));
    chk("cnt_b", 32'(bus_b.match_cnt), 32'(m_cnt_b));
  endtask

  task automatic sb(input logic d);
    step(1'b0, 1'b1, d, ovl, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, ovl, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) sb(bits[k]);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, ovl, 1'b0, 8'h00, 4'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, ovl, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] li);
    step(1'b0, 1'b1, 1'b1, ovl, 1'b1, p, li, 1'b0);
  endtask

  initial begin
    ovl = MODE_OVL;
    do_reset();
    chk("rst_z", 32'(bus_a.z), 32'd0);
    chk("rst_cnt", 32'(bus_a.match_cnt), 32'd0);

    // default pattern 1101, overlapping: pulses after bits 4 and 7
    feed(32'b1101101, 7);
    chk("ovl_cnt", 32'(bus_a.match_cnt), 32'd2);

    ovl = MODE_NOVL;
    do_reset();
    feed(32'b1101101, 7);
    chk("novl_cnt", 32'(bus_a.match_cnt), 32'd1);
    feed(32'b1101, 4);
    chk("novl_cnt2", 32'(bus_a.match_cnt), 32'd2);

    // en gaps never break a partial match
    do_reset();
    for (int k = 3; k >= 0; k--) begin
      sb(4'b1101 >> k);
      idle();
      idle();
    end
    chk("gap_cnt", 32'(bus_a.match_cnt), 32'd1);

    // load discards the simultaneous bit, then 010 overlapping in 01010
    ovl = MODE_OVL;
    load(8'b010, 4'd3);
    chk("load_armed", 32'(bus_a.armed), 32'd0);
    feed(32'b01010, 5);
    chk("load_cnt", 32'(bus_a.match_cnt), 32'd3);

    load(8'b1, 4'd0);
    feed(32'b0110, 4);
    load(8'b1010_0101, 4'd15);
    feed(32'b1010_0101_0, 9);

    // saturation on the 4-bit counter, then clear on a match edge
    do_reset();
    load(8'b1, 4'd1);
    for (int k = 0; k < 20; k++) sb(1'b1);
    chk("sat_b", 32'(bus_b.match_cnt), 32'd15);
    chk("sat_a", 32'(bus_a.match_cnt), 32'd20);
    step(1'b0, 1'b1, 1'b1, ovl, 1'b0, 8'h00, 4'd0, 1'b1);
    chk("clr_z", 32'(bus_a.z), 32'd1);
    chk("clr_cnt", 32'(bus_b.match_cnt), 32'd0);

    // randomized traffic with short patterns so matches are frequent
    for (int k = 0; k < 600; k++) begin
      logic r, e, d, l, c;
      logic [7:0] p;
      logic [3:0] li;
      r  = ($urandom % 80) == 0;
      l  = ($urandom % 30) == 0;
      c  = ($urandom % 40) == 0;
      e  = ($urandom % 4) != 0;
      d  = 1'($urandom);
      p  = 8'($urandom);
      li = ($urandom % 8 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      if ($urandom % 20 == 0) ovl = ~ovl;
      step(r, e, d, ovl, l, p, li, c);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised successor to the fixed-pattern serial sequence detector.
- Detects a run-time programmable bit pattern of length 1..MAX_LEN on a 1-bit serial input.
- Supports overlapping and non-overlapping detection modes and an input-valid qualifier.
- Keeps a saturating match counter; used by the bit-stream monitors as a drop-in replacement for single-pattern detectors.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- LEN_W, 4: width of the length field; must hold MAX_LEN, i.e. $clog2(MAX_LEN+1).
- CNT_W, 8: width of the match counter.
- DEFAULT_PAT, 8'b0000_1101: pattern loaded at reset, LSB-aligned.
- DEFAULT_LEN, 4: pattern length loaded at reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in  in  1  serial data bit
- en  in  1  in is sampled only when en=1
- mode_ovl  in  1  1 = overlapping detection, 0 = non-overlapping
- pat_load  in  1  load pat_in/len_in this cycle
- pat_in  in  MAX_LEN  new pattern, LSB-aligned
- len_in  in  LEN_W  new pattern length
- cnt_clr  in  1  clear match counter
- z  out  1  registered one-cycle match pulse
- armed  out  1  history holds at least len valid bits
- match_cnt  out  CNT_W  saturating count of matches

Behaviour:
- Single clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: hist=0, fill=0, pat=DEFAULT_PAT, len=DEFAULT_LEN, z=0, armed=0, match_cnt=0. rst overrides every other input.
- Bit order: the first received bit of the pattern compares to pat[len-1]; the last received bit compares to pat[0].
- Sample (en=1, pat_load=0):
  - hist_n = {hist[MAX_LEN-2:0], in}.
  - fill_n = min(fill+1, MAX_LEN).
  - match = (fill_n >= len) && (hist_n[len-1:0] == pat[len-1:0]); bits above len are masked.
- Latency: z=1 in exactly the cycle after the edge that samples the final pattern bit. z=0 in every other cycle, including all en=0 cycles.
- On match:
  - Overlap mode: fill continues unchanged.
  - Non-overlap mode: fill is set to 0 on that edge, so no bit of the matched sequence is reused.
- en=0: hist, fill and z hold their values except that z is forced to 0. Idle cycles never break a partial match.
- pat_load=1:
  - pat <= pat_in. len <= clamp(len_in, 1, MAX_LEN): 0 becomes 1, anything above MAX_LEN becomes MAX_LEN.
  - hist and fill cleared, z=0.
  - Any simultaneous en/in bit is discarded; load wins.
  - match_cnt is unaffected.
- mode_ovl is sampled every edge. Changing it mid-stream affects only the next match decision; no flush occurs.
- armed = registered (fill >= len), updated with fill.
- match_cnt:
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority: when cnt_clr is asserted on the same edge as a match, the count becomes 0, but z still pulses.
- Reset mid-stream: all partial history is lost and the pattern reverts to DEFAULT_PAT/DEFAULT_LEN.

Decomposition:
- Package seq_det_pkg holds:
  - MODE_NOVL=1'b0 and MODE_OVL=1'b1
  - the clamp-length function
  - default pattern/length constants shared with the benches
- One sub-module, seq_det_hist: the history shift register plus saturating fill counter, with a clear input.
- The top level holds the pattern/length registers, the masked compare, z, armed and match_cnt.

Test Plan:
- Reset: assert rst for 2 cycles with en=1, in=1 -> z=0, armed=0, match_cnt=0; default pattern 1101 is detected afterwards.
- Overlap: mode_ovl=1, en=1, stream 1,1,0,1,1,0,1 -> z pulses in the cycles after bit 4 and bit 7; match_cnt=2.
- Non-overlap: mode_ovl=0, same stream 1,1,0,1,1,0,1 -> z only after bit 4; match_cnt=1. Appending 1,1,0,1 gives a second pulse after bit 11.
- en gating: stream 1,1,0,1 with two en=0 cycles after each bit -> exactly one z pulse, one cycle after the final sampled bit; z=0 during gaps.
- Load:
  - pat_load with pat_in=3'b010, len_in=3, while en=1, in=1 -> that bit is discarded and armed=0.
  - Then overlap stream 0,1,0,1,0 -> 2 pulses.
  - Then len_in=0 loads len=1, and len_in=15 loads len=8.
- Saturation/clear: CNT_W=4, pattern 1/len 1, 20 consecutive 1s -> match_cnt stops at 15. cnt_clr on a match edge -> match_cnt=0 and z=1.
